// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander: loads a 16-word block, then streams W[0..63]
// while a 16-word sliding window computes each next word with the small-sigma functions.

module sha256_sigma0 (
    input  logic [31:0] x,
    output logic [31:0] y
);
    assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
endmodule

module sha256_sigma1 (
    input  logic [31:0] x,
    output logic [31:0] y
);
    assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
endmodule

module sha256_msg_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_data,
    output logic [5:0]  w_index,
    output logic        w_last,
    output logic        busy
);
    typedef enum logic {
        LOAD = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] win [16];
    logic [3:0]  lcnt;
    logic [5:0]  t;
    logic        last_q;
    logic        in_fire;
    logic        w_fire;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] w_next;

    assign in_fire = in_valid & in_ready;
    assign w_fire  = w_valid & w_ready;

    sha256_sigma0 u_sigma0 (
        .x (win[1]),
        .y (s0)
    );

    sha256_sigma1 u_sigma1 (
        .x (win[14]),
        .y (s1)
    );

    // Next window tail: W[t+16] from W[t+14], W[t+9], W[t+1], W[t]; carries drop off at 32 bits.
    always_comb begin
        w_next = s1 + win[9] + s0 + win[0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (in_fire && lcnt == 4'd15) state_d = EMIT;
            EMIT:    if (w_fire && t == 6'd63)     state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        in_ready = (state_q == LOAD);
        w_valid  = (state_q == EMIT);
        busy     = (state_q == EMIT);
        w_data   = win[0];
        w_index  = t;
        w_last   = last_q;
    end

    // NOTE: the window is reset because win[0] is visible on w_data and must read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) win[i] <= '0;
            lcnt   <= '0;
            t      <= '0;
            last_q <= 1'b0;
        end else if (in_fire) begin
            win[lcnt] <= in_data;
            lcnt      <= lcnt + 4'd1;
            t         <= '0;
            last_q    <= 1'b0;
        end else if (w_fire) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= w_next;
            t       <= t + 6'd1;
            // w_last is registered one step ahead so the output needs no compare logic.
            last_q  <= (t == 6'd62);
        end
    end

endmodule
